// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - frame constants (header / checksum / byte / word widths)
//   - default memory depth
//   - loader state encoding
package imem_loader_pkg;

    localparam int DEPTH_DEF = 32;
    localparam int HDR_W     = 8;
    localparam int CHK_W     = 8;
    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_WR   = 3'd3,
        ST_CHK  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
//   s_valid_i / s_data_i / s_ready_o : byte stream (source -> loader)
//   im_we_o / im_addr_o / im_data_o  : word writes (loader -> memory)
// modport slave  : loader side
// modport master : stream source / memory model side
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int AW = 5
) ();
    logic              s_valid_i;
    logic [BYTE_W-1:0] s_data_i;
    logic              s_ready_o;
    logic              im_we_o;
    logic [AW-1:0]     im_addr_o;
    logic [WORD_W-1:0] im_data_o;

    modport slave (
        input  s_valid_i, s_data_i,
        output s_ready_o, im_we_o, im_addr_o, im_data_o
    );

    modport master (
        output s_valid_i, s_data_i,
        input  s_ready_o, im_we_o, im_addr_o, im_data_o
    );
endinterface

// File: rtl/imem_loader_asm.sv
// Byte-to-word assembler: 32-bit shift register (new byte enters bits 7:0)
// and a 2-bit byte counter.
//   clk_i, rst_i : clock, async active-low reset
//   clr_i        : clear counter and register at the start of a load
//   shift_i      : accept byte_i this cycle
//   byte_i       : incoming byte
//   word_o       : assembled word (complete after the 4th shift)
//   last_o       : the byte currently offered is the 4th of a word
module imem_loader_asm
    import imem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              last_o
);
    logic [WORD_W-1:0] sr_q;
    logic [1:0]        cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (shift_i) begin
            sr_q  <= {sr_q[WORD_W-BYTE_W-1:0], byte_i};
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign word_o = sr_q;
    assign last_o = (cnt_q == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream (header N, 4*N data bytes MSB
// first, XOR checksum of the data bytes) and writes N words into
// instruction memory, releasing the CPU reset only after a good checksum.
//   clk_i, rst_i : clock, async active-low reset
//   start_i      : begin a load (honoured in IDLE / DONE / ERR)
//   bus          : byte stream in, memory write out (imem_loader_if.slave)
//   cpu_rst_o    : active-low CPU reset, high only after a good load
//   busy_o       : load in progress
//   done_o       : one-cycle pulse on success
//   err_o        : high while in ERR
//
// state | meaning
// IDLE  | after reset, waiting for start_i
// HDR   | waiting for the word-count byte
// DATA  | collecting the 4 bytes of a word
// WR    | one-cycle memory write of the assembled word
// CHK   | waiting for the checksum byte
// DONE  | load good, CPU released, waiting for start_i
// ERR   | bad header or checksum, CPU held, waiting for start_i
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    imem_loader_if.slave bus,
    output logic         cpu_rst_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);
    localparam int IW = AW + 1;   // one extra bit so the index can reach N=DEPTH
    localparam logic [HDR_W-1:0] DEPTH_B = HDR_W'(DEPTH);

    state_t            state_q, state_d;
    logic              s_ready, start_clr, asm_last;
    logic [HDR_W-1:0]  n_q;
    logic [IW-1:0]     idx_q, idx_inc;
    logic [CHK_W-1:0]  csum_q;
    logic [AW-1:0]     addr_hold_q;
    logic [WORD_W-1:0] data_hold_q, asm_word;
    logic              done_q, cpu_rst_q;
    logic              accept;

    assign idx_inc = idx_q + 1'b1;
    assign accept  = bus.s_valid_i & s_ready;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        busy_o    = 1'b0;
        err_o     = 1'b0;
        start_clr = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                err_o = (state_q == ST_ERR);
                if (start_i) begin
                    state_d   = ST_HDR;
                    start_clr = 1'b1;
                end
            end
            ST_HDR: begin
                s_ready = 1'b1;
                busy_o  = 1'b1;
                if (bus.s_valid_i) begin
                    if (bus.s_data_i == '0)          state_d = ST_CHK;
                    else if (bus.s_data_i > DEPTH_B) state_d = ST_ERR;
                    else                             state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                s_ready = 1'b1;
                busy_o  = 1'b1;
                if (bus.s_valid_i && asm_last) state_d = ST_WR;
            end
            ST_WR: begin
                busy_o  = 1'b1;
                state_d = (HDR_W'(idx_inc) == n_q) ? ST_CHK : ST_DATA;
            end
            ST_CHK: begin
                s_ready = 1'b1;
                busy_o  = 1'b1;
                if (bus.s_valid_i)
                    state_d = (bus.s_data_i == csum_q) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            n_q         <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
            done_q      <= 1'b0;
            cpu_rst_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_clr) begin
                idx_q     <= '0;
                csum_q    <= '0;
                cpu_rst_q <= 1'b0;
            end
            if (state_q == ST_HDR && accept)
                n_q <= bus.s_data_i;
            if (state_q == ST_DATA && accept)
                csum_q <= csum_q ^ bus.s_data_i;
            if (state_q == ST_WR) begin
                addr_hold_q <= idx_q[AW-1:0];
                data_hold_q <= asm_word;
                idx_q       <= idx_inc;
            end
            if (state_q == ST_CHK && accept && bus.s_data_i == csum_q) begin
                done_q    <= 1'b1;
                cpu_rst_q <= 1'b1;
            end
        end
    end

    imem_loader_asm u_asm (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (start_clr),
        .shift_i (state_q == ST_DATA && accept),
        .byte_i  (bus.s_data_i),
        .word_o  (asm_word),
        .last_o  (asm_last)
    );

    // The shift register is stable during WR (no byte accepted), so it drives
    // the write directly; the hold registers keep the last write visible.
    assign bus.s_ready_o = s_ready;
    assign bus.im_we_o   = (state_q == ST_WR);
    assign bus.im_addr_o = (state_q == ST_WR) ? idx_q[AW-1:0] : addr_hold_q;
    assign bus.im_data_o = (state_q == ST_WR) ? asm_word : data_hold_q;
    assign done_o        = done_q;
    assign cpu_rst_o     = cpu_rst_q;
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk_i   = 1'b0;
    logic rst_i   = 1'b1;
    logic start_i = 1'b0;
    logic cpu_rst_o, busy_o, done_o, err_o;

    imem_loader_if #(.AW(AW)) bus ();

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .bus       (bus),
        .cpu_rst_o (cpu_rst_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    logic [AW+31:0] wr_q[$];
    int   we_double = 0;
    int   bad_rise  = 0;
    logic prev_we   = 1'b0;
    logic prev_cr   = 1'b0;
    always @(negedge clk_i) begin
        if (bus.im_we_o) wr_q.push_back({bus.im_addr_o, bus.im_data_o});
        if (bus.im_we_o && prev_we) we_double <= we_double + 1;
        if (cpu_rst_o && !prev_cr && !done_o) bad_rise <= bad_rise + 1;
        prev_we <= bus.im_we_o;
        prev_cr <= cpu_rst_o;
    end

    // ---------------- stimulus ----------------
    logic [31:0] fw[$];   // words of the frame under construction

    function automatic logic [7:0] xsum_of_fw();
        logic [7:0] x = 8'h00;
        foreach (fw[w]) x = x ^ fw[w][31:24] ^ fw[w][23:16] ^ fw[w][15:8] ^ fw[w][7:0];
        return x;
    endfunction

    // Called at a negedge; returns at the negedge following the last accept.
    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid.
    task automatic send_bytes(input logic [7:0] bq[$], input int mode, input bit noise);
        int i = 0;
        int k = 0;
        bit v, acc;
        while (i < bq.size() && k < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.s_valid_i = v;
            bus.s_data_i  = v ? bq[i] : 8'($urandom);
            if (noise) start_i = 1'($urandom_range(0, 1));
            acc = v && bus.s_ready_o;
            @(negedge clk_i);
            if (acc) i++;
            k++;
        end
        bus.s_valid_i = 1'b0;
        start_i       = 1'b0;
        if (i < bq.size()) check("stream_timeout", 64'(i), 64'(bq.size()));
    endtask

    task automatic run_frame(input string name, input logic [7:0] n, input logic [7:0] chkb,
                             input int mode, input bit noise);
        logic [7:0] bq[$];
        bit exp_ok, done_seen, err_seen;
        int exp_nw, c0, c_done, t;
        logic [AW+31:0] w;

        exp_ok = (n <= DEPTH) && (chkb == xsum_of_fw());
        exp_nw = (n <= DEPTH) ? int'(n) : 0;
        bq.push_back(n);
        if (n <= DEPTH) begin
            foreach (fw[i]) for (int b = 3; b >= 0; b--) bq.push_back(fw[i][8*b +: 8]);
            bq.push_back(chkb);
        end

        wr_q.delete();
        @(negedge clk_i);
        start_i = 1'b1;
        c0 = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
        send_bytes(bq, mode, noise);

        done_seen = 0; err_seen = 0; c_done = 0; t = 0;
        while (t < 40) begin
            if (done_o) begin done_seen = 1; c_done = cyc; break; end
            if (err_o)  begin err_seen = 1; break; end
            @(negedge clk_i);
            t++;
        end
        check({name, "_outcome"}, {62'd0, done_seen, err_seen}, exp_ok ? 64'd2 : 64'd1);
        if (done_seen) begin
            check({name, "_cpu_rst_at_done"}, 64'(cpu_rst_o), 64'd1);
            check({name, "_err_clear"}, 64'(err_o), 64'd0);
            if (mode == 0) check({name, "_frame_cycles"}, 64'(c_done - c0), 64'(5 * int'(n) + 3));
            @(negedge clk_i);
            check({name, "_done_pulse"}, 64'(done_o), 64'd0);
            check({name, "_cpu_rst_hold"}, 64'(cpu_rst_o), 64'd1);
        end else if (err_seen) begin
            check({name, "_cpu_rst_err"}, 64'(cpu_rst_o), 64'd0);
            @(negedge clk_i);
            check({name, "_err_hold"}, 64'(err_o), 64'd1);
        end
        check({name, "_busy_end"}, 64'(busy_o), 64'd0);
        check({name, "_nwrites"}, 64'(wr_q.size()), 64'(exp_nw));
        for (int i = 0; i < exp_nw && i < wr_q.size(); i++) begin
            w = {AW'(i), fw[i]};
            check($sformatf("%s_wr%0d", name, i), 64'(wr_q[i]), 64'(w));
        end
        if (exp_nw > 0) begin
            w = {AW'(exp_nw - 1), fw[exp_nw - 1]};
            check({name, "_bus_hold"}, 64'({bus.im_addr_o, bus.im_data_o}), 64'(w));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"},   64'(bus.s_ready_o), 64'd0);
        check({name, "_we"},      64'(bus.im_we_o),   64'd0);
        check({name, "_addr"},    64'(bus.im_addr_o), 64'd0);
        check({name, "_data"},    64'(bus.im_data_o), 64'd0);
        check({name, "_cpu_rst"}, 64'(cpu_rst_o),     64'd0);
        check({name, "_busy"},    64'(busy_o),        64'd0);
        check({name, "_done"},    64'(done_o),        64'd0);
        check({name, "_err"},     64'(err_o),         64'd0);
    endtask

    initial begin
        logic [7:0] n, x;
        logic [7:0] bq[$];
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = 8'h00;

        #1 rst_i = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("idle_cpu_rst", 64'(cpu_rst_o), 64'd0);

        // two-word frame, back-to-back then with valid toggling
        fw = '{32'h20010005, 32'h2002000A};
        run_frame("two_b2b", 8'h02, xsum_of_fw(), 0, 1'b0);
        run_frame("two_toggle", 8'h02, xsum_of_fw(), 1, 1'b0);

        // oversize header, then recovery with a good frame
        fw.delete();
        run_frame("hdr_33", 8'h21, 8'h00, 0, 1'b0);
        fw = '{32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
        run_frame("recover", 8'h03, xsum_of_fw(), 2, 1'b0);

        // bad checksum: word still written, then ERR
        fw = '{32'hDEADBEEF};
        run_frame("bad_chk", 8'h01, 8'h00, 0, 1'b0);

        // reset after the 3rd data byte
        wr_q.delete();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        bq = '{8'h01, 8'h11, 8'h22, 8'h33};
        send_bytes(bq, 0, 1'b0);
        check("midframe_busy", 64'(busy_o), 64'd1);
        #2 rst_i = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        fw = '{32'hA5A5_0F0F};
        run_frame("after_rst", 8'h01, xsum_of_fw(), 0, 1'b0);

        // empty frame, then start_i noise while busy
        fw.delete();
        run_frame("empty", 8'h00, 8'h00, 0, 1'b0);
        fw = '{32'h0000_0001, 32'hFFFF_FFFF};
        run_frame("start_noise", 8'h02, xsum_of_fw(), 0, 1'b1);

        // randomized frames
        for (int r = 0; r < 12; r++) begin
            fw.delete();
            if ($urandom_range(0, 9) == 0) n = 8'($urandom_range(DEPTH + 1, 255));
            else                           n = 8'($urandom_range(0, 6));
            if (n <= DEPTH) for (int i = 0; i < int'(n); i++) fw.push_back($urandom);
            x = xsum_of_fw();
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            run_frame($sformatf("rnd%0d", r), n, x, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        check("we_single_cycle", 64'(we_double), 64'd0);
        check("cpu_rst_rise_only_at_done", 64'(bad_rise), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
